// File: rtl/add4_accumulator.sv
// Sequencer for the 4-bit ripple adder: registers the operands, waits for the
// ripple chain to settle, then folds sum/carry back into the accumulator.
module add4_accumulator #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_out,
    output logic             ovf_out,
    output logic             out_valid
);

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    localparam int         MSB      = WIDTH - 1;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_ADC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             ovf_q;
    logic             valid_q;

    logic             accept;
    logic             ovf_d;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // Signed overflow: like-signed operands yielding an opposite-signed sum
    assign ovf_d = (a_q[MSB] == b_q[MSB]) && (add_sum[MSB] != a_q[MSB]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (in_op)
                            OP_ADD, OP_ADC: begin
                                a_q     <= acc_q;
                                b_q     <= in_data;
                                cin_q   <= (in_op == OP_ADC) ? carry_q : 1'b0;
                                cnt_q   <= CNT_INIT;
                                state_q <= SETTLE;
                            end
                            OP_LOAD: begin
                                acc_q   <= in_data;
                                carry_q <= 1'b0;
                                ovf_q   <= 1'b0;
                                valid_q <= 1'b1;
                            end
                            OP_CLEAR: begin
                                acc_q   <= '0;
                                carry_q <= 1'b0;
                                ovf_q   <= 1'b0;
                                valid_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        acc_q   <= add_sum;
                        carry_q <= add_cout;
                        ovf_q   <= ovf_d;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign acc_out   = acc_q;
    assign carry_out = carry_q;
    assign ovf_out   = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_add4_accumulator.sv
// Bench for add4_accumulator: directed scenarios plus random commands
// checked against an arithmetic reference model.
module tb_add4_accumulator;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_op = 2'b00;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;
    logic [W-1:0] acc_out;
    logic         carry_out;
    logic         ovf_out;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    int exp_acc = 0;
    int exp_c   = 0;
    int exp_v   = 0;

    always #5 clk = ~clk;

    // The external ripple adder, ideal (zero delay)
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    add4_accumulator #(
        .WIDTH(W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_data(in_data),
        .add_a(add_a),
        .add_b(add_b),
        .add_cin(add_cin),
        .add_sum(add_sum),
        .add_cout(add_cout),
        .acc_out(acc_out),
        .carry_out(carry_out),
        .ovf_out(ovf_out),
        .out_valid(out_valid)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    task automatic do_cmd(input logic [1:0] op, input int d);
        int cin;
        int ea;
        int s;
        int ss;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = 4'(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_data  = 4'($urandom);
        if (op == 2'b00 || op == 2'b01) begin
            cin = (op == 2'b01) ? exp_c : 0;
            ea  = exp_acc;
            for (int k = 0; k < S; k++) begin
                chk("settle_valid", int'(out_valid), 0);
                chk("settle_ready", int'(in_ready), 0);
                chk("settle_a", int'(add_a), ea);
                chk("settle_b", int'(add_b), d);
                chk("settle_cin", int'(add_cin), cin);
                @(posedge clk);
                #1;
            end
            s       = ea + d + cin;
            ss      = sgn(ea) + sgn(d) + cin;
            exp_acc = s % 16;
            exp_c   = (s > 15) ? 1 : 0;
            exp_v   = (ss > 7 || ss < -8) ? 1 : 0;
        end else begin
            exp_acc = (op == 2'b10) ? d : 0;
            exp_c   = 0;
            exp_v   = 0;
        end
        chk("done_valid", int'(out_valid), 1);
        chk("done_acc", int'(acc_out), exp_acc);
        chk("done_carry", int'(carry_out), exp_c);
        chk("done_ovf", int'(ovf_out), exp_v);
        chk("done_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("pulse_width", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int pe[$];
        int pa[$];

        // Reset then idle
        #12;
        chk("rst_acc", int'(acc_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_a", int'(add_a), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("idle_acc", int'(acc_out), 0);
            chk("idle_carry", int'(carry_out), 0);
            chk("idle_ovf", int'(ovf_out), 0);
            chk("idle_valid", int'(out_valid), 0);
            chk("idle_ready", int'(in_ready), 1);
        end

        // LOAD 5, ADD 3
        do_cmd(2'b10, 5);
        chk("load5_acc", int'(acc_out), 5);
        do_cmd(2'b00, 3);
        chk("add3_acc", int'(acc_out), 8);
        chk("add3_carry", int'(carry_out), 0);
        chk("add3_ovf", int'(ovf_out), 1);

        // Wrap and chain
        do_cmd(2'b10, 15);
        do_cmd(2'b00, 1);
        chk("wrap_acc", int'(acc_out), 0);
        chk("wrap_carry", int'(carry_out), 1);
        chk("wrap_ovf", int'(ovf_out), 0);
        do_cmd(2'b01, 0);
        chk("adc_cin", int'(add_cin), 1);
        chk("adc_acc", int'(acc_out), 1);
        chk("adc_carry", int'(carry_out), 0);

        // Back-to-back: in_valid held for three ADD 2 from acc=0
        do_cmd(2'b11, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 4'd2;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (e == 6) in_valid = 1'b0;
            if (out_valid) begin
                pe.push_back(e);
                pa.push_back(int'(acc_out));
            end
        end
        chk("b2b_count", pe.size(), 3);
        if (pe.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("b2b_edge", pe[i], 2 + 3 * i);
                chk("b2b_acc", pa[i], 2 + 2 * i);
            end
        end
        exp_acc = 6;
        exp_c   = 0;
        exp_v   = 0;
        chk("b2b_final", int'(acc_out), 6);

        // Async reset one cycle into SETTLE
        do_cmd(2'b10, 9);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_acc", int'(acc_out), 0);
        chk("arst_carry", int'(carry_out), 0);
        chk("arst_ovf", int'(ovf_out), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_a", int'(add_a), 0);
        chk("arst_b", int'(add_b), 0);
        chk("arst_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_acc = 0;
        exp_c   = 0;
        exp_v   = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", int'(out_valid), 0);
            chk("post_rst_ready", int'(in_ready), 1);
            chk("post_rst_acc", int'(acc_out), 0);
        end

        // CLEAR after overflow
        do_cmd(2'b10, 7);
        do_cmd(2'b00, 1);
        chk("ovf_acc", int'(acc_out), 8);
        chk("ovf_flag", int'(ovf_out), 1);
        do_cmd(2'b11, 0);
        chk("clear_acc", int'(acc_out), 0);
        chk("clear_ovf", int'(ovf_out), 0);

        // Random commands against the model
        for (int i = 0; i < 60; i++) begin
            do_cmd(2'($urandom), int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add4_accumulator.md
Name: add4_accumulator

Overview:
- Sequencing stage that sits directly upstream of the 4-bit ripple full adder and also consumes its result.
- Drives the adder's A/B/carry-in from registered operands: A is the running accumulator, B is the incoming operand.
- Waits a programmable number of clock cycles for the ripple chain to settle, then captures sum and carry-out back into the accumulator.
- Presents operands to the rest of the lab design through a valid/ready handshake.

Parameters:
- WIDTH, 4, operand/accumulator width; must match the adder width.
- SETTLE_CYCLES, 2, clock cycles the adder outputs are given to settle before capture; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/command present
- in_ready  output  1  block can accept a command
- in_op  input  2  command: 00 ADD, 01 ADC (add with stored carry), 10 LOAD, 11 CLEAR
- in_data  input  WIDTH  operand
- add_a  output  WIDTH  to adder inA
- add_b  output  WIDTH  to adder inB
- add_cin  output  1  to adder cin
- add_sum  input  WIDTH  from adder sum
- add_cout  input  1  from adder cout
- acc_out  output  WIDTH  accumulator value
- carry_out  output  1  stored carry flag
- ovf_out  output  1  stored signed-overflow flag
- out_valid  output  1  one-cycle pulse: acc_out/flags just updated

Behaviour:
- Reset (async, immediate on rst high):
  - acc_out=0, carry_out=0, ovf_out=0, out_valid=0.
  - add_a=0, add_b=0, add_cin=0, state=IDLE, settle counter=0.
- States: IDLE, SETTLE.
- in_ready = (state==IDLE), combinational from the state register only.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready. in_op and in_data are ignored at all other times.
- IDLE, accept with ADD or ADC:
  - add_a<=acc_out, add_b<=in_data.
  - add_cin<=0 for ADD; add_cin<=carry_out for ADC.
  - cnt<=SETTLE_CYCLES-1, state<=SETTLE.
- IDLE, accept with LOAD:
  - acc_out<=in_data, carry_out<=0, ovf_out<=0, out_valid<=1.
  - State stays IDLE; the adder drive registers are unchanged.
- IDLE, accept with CLEAR:
  - acc_out<=0, carry_out<=0, ovf_out<=0, out_valid<=1, state stays IDLE.
- SETTLE:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0, capture:
    - acc_out<=add_sum, carry_out<=add_cout.
    - ovf_out<=(add_a[MSB]==add_b[MSB]) && (add_sum[MSB]!=add_a[MSB]).
    - out_valid<=1, state<=IDLE.
- Latency:
  - ADD/ADC: out_valid is high in the cycle following the SETTLE_CYCLES-th edge after the accept edge. With the default, accept at edge E0 gives capture at E2.
  - LOAD/CLEAR: out_valid is high in the cycle following the accept edge.
- out_valid is exactly one cycle wide; it is cleared on every edge that does not set it.
- in_ready rises in the same cycle that out_valid pulses after an ADD/ADC, so back-to-back commands are legal. Throughput is one ADD per SETTLE_CYCLES+1 cycles.
- add_a/add_b/add_cin stay stable throughout SETTLE and hold their last values in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. The carry out of the MSB goes to carry_out only; acc_out never widens.
- Wrap-around example: acc=15, ADD 1 -> acc=0, carry=1, ovf=0.
- ADC chains multi-nibble sums. The stored carry is consumed as add_cin, and carry_out is then overwritten by the new add_cout.
- in_valid held high while in_ready is low: the command is neither accepted nor lost. It is taken on the first edge with in_ready=1.
- rst asserted mid-SETTLE: the operation is aborted with no capture and no out_valid. All registers return to their reset values.
- The adder's own propagation delay is not modelled by this block. SETTLE_CYCLES*clock period must exceed the worst-case ripple delay.

Test Plan:
- Reset then idle: rst pulse, no in_valid -> acc_out=0, carry_out=0, ovf_out=0, out_valid=0, in_ready=1 throughout.
- LOAD 5 then ADD 3, SETTLE_CYCLES=2:
  - LOAD -> out_valid one cycle after the accept, acc=5.
  - ADD -> add_a=5, add_b=3, add_cin=0 held through SETTLE; in_ready=0 for 2 cycles; then acc=8, carry=0, ovf=1 (0101+0011 gives signed overflow).
- Wrap and chain:
  - LOAD 15, ADD 1 -> acc=0, carry=1.
  - Then ADC 0 -> add_cin=1, acc=1, carry=0.
- Back-to-back with in_valid held high for 3 ADD 2 commands from acc=0 -> exactly three out_valid pulses, spaced 3 cycles apart; acc sequence 2, 4, 6; no command dropped or duplicated.
- Async reset mid-SETTLE: LOAD 9, ADD 7, assert rst one cycle into SETTLE -> outputs go to 0 immediately with no clock edge; no out_valid; in_ready=1 after rst falls.
- CLEAR after overflow: LOAD 7, ADD 1 (acc=8, ovf=1), then CLEAR -> acc=0, carry=0, ovf=0, out_valid pulse one cycle after the accept.
